// File: rtl/pixel_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_tx
// Description : Reads one frame of pixels from a result buffer in raster order
//               and streams it out over a valid/ready interface. Frame
//               markers (start-of-frame, end-of-line, end-of-frame) travel
//               with each pixel. A 2-entry output FIFO (output register plus
//               skid register) absorbs back-pressure, and reads are
//               credit-limited so that this FIFO can never overflow.
// Ports       : clk, reset         - clock, asynchronous active-high reset
//               start              - one-cycle frame request (IDLE only)
//               busy, done         - frame in progress / one-cycle completion
//               mem_rd_en/addr     - result-buffer read strobe and address
//               mem_rd_data        - read data, valid 1 cycle after strobe
//               m_valid/m_ready    - output handshake
//               m_data, m_sof,
//               m_eol, m_eof       - pixel value and frame markers
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_stream_tx #(
    parameter int IMAGE_WIDTH  = 400,
    parameter int IMAGE_HEIGHT = 500,
    parameter int PIXEL_WIDTH  = 8,
    parameter int ADDR_WIDTH   = 18
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
    input  logic [PIXEL_WIDTH-1:0] mem_rd_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [PIXEL_WIDTH-1:0] m_data,
    output logic                   m_sof,
    output logic                   m_eol,
    output logic                   m_eof
);

    // Counter widths stay at least 1 bit so a 1-pixel dimension still elaborates.
    localparam int XW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    // FIFO entry layout: {sof, eol, eof, data}
    localparam int EW = PIXEL_WIDTH + 3;

    localparam logic [XW-1:0]         c_X_LAST   = XW'(IMAGE_WIDTH - 1);
    localparam logic [YW-1:0]         c_Y_LAST   = YW'(IMAGE_HEIGHT - 1);
    localparam logic [XW-1:0]         c_X_ONE    = XW'(1);
    localparam logic [YW-1:0]         c_Y_ONE    = YW'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic [XW-1:0]           x_q,         x_d;
    logic [YW-1:0]           y_q,         y_d;
    logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic                    rd_done_q,   rd_done_d;
    logic                    pipe_vld_q,  pipe_vld_d;
    logic [2:0]              pipe_mark_q, pipe_mark_d;
    logic                    out_vld_q,   out_vld_d;
    logic [EW-1:0]           out_q,       out_d;
    logic                    skid_vld_q,  skid_vld_d;
    logic [EW-1:0]           skid_q,      skid_d;

    logic                    w_xfer;
    logic [1:0]              w_occ;
    logic                    w_rd_en;
    logic                    w_wr_en;
    logic [EW-1:0]           w_wr_entry;
    logic                    w_sof;
    logic                    w_eol;
    logic                    w_eof;

    assign w_xfer = out_vld_q & m_ready;

    // Entries held plus the read still in flight; a transfer this cycle frees
    // one slot, so the limit is raised by one when it happens.
    assign w_occ   = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, pipe_vld_q};
    assign w_rd_en = (state_q == S_STREAM) && !rd_done_q
                     && (w_occ < (2'd2 + {1'b0, w_xfer}));

    assign w_sof = (x_q == '0) && (y_q == '0);
    assign w_eol = (x_q == c_X_LAST);
    assign w_eof = w_eol && (y_q == c_Y_LAST);

    // Read data returns one cycle after the strobe; markers wait alongside it.
    assign w_wr_en    = pipe_vld_q;
    assign w_wr_entry = {pipe_mark_q, mem_rd_data};

    // FSM and read-side counters
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        rd_done_d   = rd_done_q;
        pipe_vld_d  = w_rd_en;
        pipe_mark_d = {w_sof, w_eol, w_eof};

        case (state_q)
            S_IDLE: begin
                x_d       = '0;
                y_d       = '0;
                addr_d    = '0;
                rd_done_d = 1'b0;
                if (start) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_xfer && out_q[PIXEL_WIDTH]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_rd_en) begin
            addr_d = addr_q + c_ADDR_ONE;
            if (x_q == c_X_LAST) begin
                x_d = '0;
                if (y_q == c_Y_LAST) begin
                    y_d       = '0;
                    rd_done_d = 1'b1;
                end else begin
                    y_d = y_q + c_Y_ONE;
                end
            end else begin
                x_d = x_q + c_X_ONE;
            end
        end
    end

    // Output register plus skid register. The skid entry only fills while the
    // output register is occupied and stalled, and it drains into the output
    // register first so ordering is preserved.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_d      = out_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;

        if (!out_vld_q || w_xfer) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_d      = skid_q;
                skid_vld_d = w_wr_en;
                if (w_wr_en) begin
                    skid_d = w_wr_entry;
                end
            end else begin
                out_vld_d = w_wr_en;
                if (w_wr_en) begin
                    out_d = w_wr_entry;
                end
            end
        end else if (w_wr_en) begin
            skid_vld_d = 1'b1;
            skid_d     = w_wr_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            rd_done_q   <= 1'b0;
            pipe_vld_q  <= 1'b0;
            pipe_mark_q <= '0;
            out_vld_q   <= 1'b0;
            out_q       <= '0;
            skid_vld_q  <= 1'b0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            rd_done_q   <= rd_done_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_mark_q <= pipe_mark_d;
            out_vld_q   <= out_vld_d;
            out_q       <= out_d;
            skid_vld_q  <= skid_vld_d;
            skid_q      <= skid_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign mem_rd_en   = w_rd_en;
    assign mem_rd_addr = addr_q;
    assign m_valid     = out_vld_q;
    assign m_data      = out_q[PIXEL_WIDTH-1:0];
    assign m_eof       = out_q[PIXEL_WIDTH];
    assign m_eol       = out_q[PIXEL_WIDTH+1];
    assign m_sof       = out_q[PIXEL_WIDTH+2];

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_stream_tx
// Description : Self-checking bench for pixel_stream_tx. A 4x3 instance is
//               driven through a vector table, stall, reset and random-ready
//               frames against a frame-level reference model; a 1x1 instance
//               covers the single-pixel frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_tx;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int PW = 8;
    localparam int AW = 18;

    logic          clk;
    logic          reset;

    logic          start, busy, done, rd_en, m_valid, m_ready, m_sof, m_eol, m_eof;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_data, m_data;

    logic          start1, busy1, done1, rd_en1, m_valid1, m_ready1, m_sof1, m_eol1, m_eof1;
    logic [AW-1:0] rd_addr1;
    logic [PW-1:0] rd_data1, m_data1;

    int n_vec = 0;
    int n_err = 0;
    int mem_salt = 0;

    pixel_stream_tx #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .PIXEL_WIDTH (PW),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (rd_en),
        .mem_rd_addr(rd_addr),
        .mem_rd_data(rd_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .m_eof      (m_eof)
    );

    pixel_stream_tx #(
        .IMAGE_WIDTH (1),
        .IMAGE_HEIGHT(1),
        .PIXEL_WIDTH (PW),
        .ADDR_WIDTH  (AW)
    ) dut1 (
        .clk        (clk),
        .reset      (reset),
        .start      (start1),
        .busy       (busy1),
        .done       (done1),
        .mem_rd_en  (rd_en1),
        .mem_rd_addr(rd_addr1),
        .mem_rd_data(rd_data1),
        .m_valid    (m_valid1),
        .m_ready    (m_ready1),
        .m_data     (m_data1),
        .m_sof      (m_sof1),
        .m_eol      (m_eol1),
        .m_eof      (m_eof1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer contents: pixel i holds (i + salt) mod 256; salt 0 gives memory[i] = i.
    function automatic logic [PW-1:0] pix(input int i, input int salt);
        return 8'((i + salt) & 255);
    endfunction

    // Read latency of exactly one cycle; garbage is returned when not reading.
    always @(posedge clk) rd_data  <= rd_en  ? pix(int'(rd_addr), mem_salt) : 8'($urandom);
    always @(posedge clk) rd_data1 <= rd_en1 ? 8'hA5 : 8'($urandom);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          start;
        logic          ready;
        logic          busy;
        logic          done;
        logic          rd_en;
        logic [AW-1:0] addr;
        logic          valid;
        logic [PW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } vec_t;

    vec_t tbl[17];

    // One whole frame on the 4x3 instance, checked against the frame model:
    // the accepted stream must be pixel 0..N-1 in order with markers derived
    // from the pixel index, reads sequential, at most 2 reads ahead of accepts.
    task automatic run_frame(input int ready_pct, input int stall_cycles,
                             input int salt, input bit noisy_start);
        int       rd_cnt, acc, dones, last_hs, cyc;
        logic     prev_stall;
        logic [10:0] prev_word;
        bit       finished;
        rd_cnt = 0; acc = 0; dones = 0; last_hs = -10; cyc = 0;
        prev_stall = 1'b0; prev_word = '0; finished = 1'b0;
        mem_salt = salt;
        start = 1'b1;
        while (!finished && cyc < 400) begin
            if (cyc > 0) start = noisy_start && (dones == 0) && ($urandom_range(3) == 0);
            m_ready = (cyc <= stall_cycles) ? 1'b0 : ($urandom_range(99) < ready_pct);
            @(negedge clk);
            if (rd_en) begin
                chk("rd_in_range", 32'(rd_cnt < N), 1);
                chk("rd_addr", 32'(rd_addr), rd_cnt);
                rd_cnt++;
            end
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 1);
                chk("hold_word", 32'({m_sof, m_eol, m_eof, m_data}), 32'(prev_word));
            end
            if (stall_cycles > 0 && cyc == stall_cycles) begin
                chk("stall_reads", rd_cnt, 2);
                chk("stall_valid", 32'(m_valid), 1);
                chk("stall_data", 32'(m_data), 32'(pix(0, salt)));
                chk("stall_sof", 32'(m_sof), 1);
            end
            if (m_valid && m_ready) begin
                chk("px_data", 32'(m_data), 32'(pix(acc, salt)));
                chk("px_sof", 32'(m_sof), 32'(acc == 0));
                chk("px_eol", 32'(m_eol), 32'(acc % W == W - 1));
                chk("px_eof", 32'(m_eof), 32'(acc == N - 1));
                acc++;
                last_hs = cyc;
            end
            chk("outstanding", 32'((rd_cnt - acc) <= 2), 1);
            if (dones > 0) begin
                chk("busy_after_done", 32'(busy), 0);
                chk("done_once", 32'(done), 0);
                finished = 1'b1;
            end else if (done) begin
                chk("done_timing", cyc, last_hs + 1);
                chk("done_no_valid", 32'(m_valid), 0);
                chk("busy_in_done", 32'(busy), 1);
                dones++;
            end else begin
                chk("busy", 32'(busy), 32'(cyc >= 1));
            end
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_sof, m_eol, m_eof, m_data};
            step();
            cyc++;
        end
        start = 1'b0;
        chk("frame_finished", 32'(finished), 1);
        chk("acc_total", acc, N);
        chk("rd_total", rd_cnt, N);
    endtask

    initial begin
        int  acc;
        bit  hit;
        int  guard;

        reset = 1'b1; start = 1'b0; m_ready = 1'b0; start1 = 1'b0; m_ready1 = 1'b0;

        // Reset values, reached asynchronously before any clock edge.
        #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_marks", 32'({m_sof, m_eol, m_eof}), 0);
        chk("rst1_valid", 32'(m_valid1), 0);
        step(); step();
        reset = 1'b0;
        step();

        // Vector table: 4x3 frame, memory[i]=i, ready always high, start at row 0.
        // Extra start pulses at row 5 (busy) and row 15 (done cycle) must be ignored.
        for (int k = 0; k < 17; k++) begin
            tbl[k].start = (k == 0) || (k == 5) || (k == 15);
            tbl[k].ready = 1'b1;
            tbl[k].busy  = (k >= 1) && (k <= 15);
            tbl[k].done  = (k == 15);
            tbl[k].rd_en = (k >= 1) && (k <= 12);
            tbl[k].addr  = AW'((k >= 1) ? k - 1 : 0);
            tbl[k].valid = (k >= 3) && (k <= 14);
            tbl[k].data  = 8'((k >= 3) ? k - 3 : 0);
            tbl[k].sof   = (k == 3);
            tbl[k].eol   = (k == 6) || (k == 10) || (k == 14);
            tbl[k].eof   = (k == 14);
        end
        mem_salt = 0;
        for (int k = 0; k < 17; k++) begin
            start   = tbl[k].start;
            m_ready = tbl[k].ready;
            @(negedge clk);
            chk("tbl_busy", 32'(busy), 32'(tbl[k].busy));
            chk("tbl_done", 32'(done), 32'(tbl[k].done));
            chk("tbl_rd_en", 32'(rd_en), 32'(tbl[k].rd_en));
            if (tbl[k].rd_en) chk("tbl_addr", 32'(rd_addr), 32'(tbl[k].addr));
            chk("tbl_valid", 32'(m_valid), 32'(tbl[k].valid));
            if (tbl[k].valid) begin
                chk("tbl_data", 32'(m_data), 32'(tbl[k].data));
                chk("tbl_marks", 32'({m_sof, m_eol, m_eof}),
                    32'({tbl[k].sof, tbl[k].eol, tbl[k].eof}));
            end
            step();
        end
        start = 1'b0;

        // Downstream held off for 10 cycles after start.
        run_frame(100, 10, 7, 1'b0);

        // Random back-pressure with stray start pulses.
        for (int f = 0; f < 6; f++) begin
            run_frame((f % 2 == 0) ? 50 : 25, 0, int'($urandom_range(255)), 1'b1);
        end

        // Reset after 5 transfers.
        mem_salt = 3;
        start = 1'b1; m_ready = 1'b1;
        acc = 0; hit = 1'b0; guard = 0;
        while (!hit && guard < 50) begin
            @(negedge clk);
            if (m_valid && m_ready) acc++;
            if (acc == 5) hit = 1'b1;
            else begin
                step();
                start = 1'b0;
                guard++;
            end
        end
        chk("reached_5_xfers", 32'(hit), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_rd_en", 32'(rd_en), 0);
        chk("arst_rd_addr", 32'(rd_addr), 0);
        chk("arst_valid", 32'(m_valid), 0);
        chk("arst_data", 32'(m_data), 0);
        chk("arst_marks", 32'({m_sof, m_eol, m_eof}), 0);
        start = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        run_frame(100, 0, 9, 1'b0);

        // 1x1 frame on the second instance.
        start1 = 1'b1; m_ready1 = 1'b1;
        @(negedge clk);
        chk("one_busy_T", 32'(busy1), 0);
        step(); start1 = 1'b0;
        @(negedge clk);
        chk("one_rd_en_T1", 32'(rd_en1), 1);
        chk("one_addr_T1", 32'(rd_addr1), 0);
        chk("one_busy_T1", 32'(busy1), 1);
        chk("one_valid_T1", 32'(m_valid1), 0);
        step();
        @(negedge clk);
        chk("one_rd_en_T2", 32'(rd_en1), 0);
        chk("one_valid_T2", 32'(m_valid1), 0);
        step();
        @(negedge clk);
        chk("one_valid_T3", 32'(m_valid1), 1);
        chk("one_data_T3", 32'(m_data1), 32'h A5);
        chk("one_marks_T3", 32'({m_sof1, m_eol1, m_eof1}), 32'b111);
        chk("one_done_T3", 32'(done1), 0);
        step();
        @(negedge clk);
        chk("one_done_T4", 32'(done1), 1);
        chk("one_valid_T4", 32'(m_valid1), 0);
        chk("one_busy_T4", 32'(busy1), 1);
        step();
        @(negedge clk);
        chk("one_done_T5", 32'(done1), 0);
        chk("one_busy_T5", 32'(busy1), 0);
        chk("one_rd_en_T5", 32'(rd_en1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
